// File: rtl/window_buf_pkg.sv
// Shared sizing helpers for the window line buffer: address widths and
// window geometry derived from the kernel radius.
package window_buf_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int win_k(input int radius);
    return 2 * radius + 1;
  endfunction

  function automatic int win_elems(input int radius);
    return win_k(radius) * win_k(radius);
  endfunction

  function automatic int centre_idx(input int radius);
    return (win_elems(radius) - 1) / 2;
  endfunction

endpackage

// File: rtl/window_line_buffer_if.sv
// Pixel-in / window-out bundle between a per-pixel stage and a kernel stage.
interface window_line_buffer_if
  import window_buf_pkg::*;
#(
  parameter int DATA_W   = 11,
  parameter int R_KERNEL = 1,
  parameter int WIDTH    = 506,
  parameter int HEIGHT   = 506
) ();
   localparam int NE = win_elems(R_KERNEL);
   localparam int XW = clog2(WIDTH);
   localparam int YW = clog2(HEIGHT);

   logic                   write;
   logic [DATA_W-1:0]      serial_in;
   logic [NE*DATA_W-1:0]   window_out;
   logic                   ready;
   logic [XW-1:0]          x_out;
   logic [YW-1:0]          y_out;
   logic                   frame_done;

   modport master (output write, serial_in,
                   input  window_out, ready, x_out, y_out, frame_done);
   modport slave  (input  write, serial_in,
                   output window_out, ready, x_out, y_out, frame_done);
endinterface

// File: rtl/window_line_buffer_line_delay.sv
// One row of delay: a circular RAM whose output is the pixel written DEPTH
// accepted pixels ago. Storage is never cleared.
module line_delay
  import window_buf_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 506
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
   localparam int AW = clog2(DEPTH);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (en) ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   // Read-before-write: the slot being overwritten holds the oldest pixel.
   always_ff @(posedge clk) begin
      if (en) mem[ptr_q] <= din;
   end

   assign dout = mem[ptr_q];
endmodule

// File: rtl/window_line_buffer.sv
// Raster pixel stream to a KxK neighbourhood window with centre coordinates,
// a fully-in-image qualifier and an end-of-frame pulse.
module window_line_buffer
  import window_buf_pkg::*;
#(
  parameter int DATA_W   = 11,
  parameter int WIDTH    = 506,
  parameter int HEIGHT   = 506,
  parameter int R_KERNEL = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   window_line_buffer_if.slave  bus
);
   localparam int K  = win_k(R_KERNEL);
   localparam int NE = win_elems(R_KERNEL);
   localparam int NL = 2 * R_KERNEL;
   localparam int XW = clog2(WIDTH);
   localparam int YW = clog2(HEIGHT);
   localparam logic [XW-1:0] COL_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] ROW_LAST = YW'(HEIGHT - 1);
   localparam logic [XW-1:0] COL_MIN  = XW'(NL);
   localparam logic [YW-1:0] ROW_MIN  = YW'(NL);
   localparam logic [XW-1:0] X_OFF    = XW'(R_KERNEL);
   localparam logic [YW-1:0] Y_OFF    = YW'(R_KERNEL);

   logic                        adv;
   logic [DATA_W-1:0]           tap [NL+1];
   logic [NE-1:0][DATA_W-1:0]   win_q, win_d;
   logic [XW-1:0]               col_q, col_d, x_q, x_d;
   logic [YW-1:0]               row_q, row_d, y_q, y_d;
   logic                        ready_q, ready_d, fd_q, fd_d;
   logic                        col_end, row_end;

   // tap[n] is the pixel n rows above the incoming one.
   assign adv    = bus.write & ~rst;
   assign tap[0] = bus.serial_in;

   generate
      for (genvar n = 0; n < NL; n++) begin : g_line
         line_delay #(.DATA_W(DATA_W), .DEPTH(WIDTH)) u_line (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .din  (tap[n]),
            .dout (tap[n+1])
         );
      end
   endgenerate

   assign col_end = (col_q == COL_LAST);
   assign row_end = (row_q == ROW_LAST);

   always_comb begin
      win_d   = win_q;
      col_d   = col_q;
      row_d   = row_q;
      x_d     = x_q;
      y_d     = y_q;
      ready_d = 1'b0;
      fd_d    = 1'b0;
      if (bus.write) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++)
               win_d[r*K + c] = win_q[r*K + c + 1];
            win_d[r*K + K - 1] = tap[NL - r];
         end
         ready_d = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
         fd_d    = col_end && row_end;
         if (ready_d) begin
            x_d = col_q - X_OFF;
            y_d = row_q - Y_OFF;
         end
         col_d = col_end ? '0 : col_q + XW'(1);
         if (col_end) row_d = row_end ? '0 : row_q + YW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         ready_q <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         win_q   <= win_d;
         col_q   <= col_d;
         row_q   <= row_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ready_q <= ready_d;
         fd_q    <= fd_d;
      end
   end

   assign bus.window_out = win_q;
   assign bus.ready      = ready_q;
   assign bus.x_out      = x_q;
   assign bus.y_out      = y_q;
   assign bus.frame_done = fd_q;
endmodule

// File: doc/window_line_buffer.md
Name: window_line_buffer

Overview:
Parametrised successor to the fixed 3x3 sobel-to-threshold buffer. It takes a raster-order pixel stream (one pixel per write strobe) and presents a full (2*R_KERNEL+1)^2 neighbourhood window with a ready qualifier. It also reports the window-centre coordinates and an end-of-frame pulse. It sits between any per-pixel stage (sobel magnitude, gradient direction, nonmax) and the next kernel stage. The same block serves value and direction channels.

Parameters:
DATA_W, 11, bits per pixel
WIDTH, 506, pixels per row; must satisfy WIDTH > 2*R_KERNEL
HEIGHT, 506, rows per frame; must satisfy HEIGHT > 2*R_KERNEL
R_KERNEL, 1, kernel radius; window side K = 2*R_KERNEL+1, R_KERNEL >= 1

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
write  in  1  pixel strobe; serial_in accepted on any rising edge where write=1
serial_in  in  DATA_W  input pixel, raster order
window_out  out  K*K*DATA_W  flattened window; element i = r*K+c at bits [i*DATA_W +: DATA_W]; r=0 oldest row, c=0 oldest column; centre is i=(K*K-1)/2
ready  out  1  window_out holds a fully in-image window
x_out  out  clog2(WIDTH)  column of window centre
y_out  out  clog2(HEIGHT)  row of window centre
frame_done  out  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (rst=1 at clock edge): col/row counters=0; ready=0, frame_done=0, window_out=0, x_out=0, y_out=0. Line-buffer RAM contents are not cleared. Reset has priority over write. After reset, the next accepted pixel is (row 0, col 0).
- Storage: 2*R_KERNEL delay lines, each WIDTH deep, chained. Window register array is K x K. On each write, every window row shifts one column left. Column K-1 loads {oldest line tap ... newest line tap, serial_in}.
- write=0: counters, delay lines and window_out hold; ready=0, frame_done=0.
- Counters: col 0..WIDTH-1; at col=WIDTH-1, col wraps to 0 and row increments. At row=HEIGHT-1 and col=WIDTH-1, both wrap to 0. The next write starts a new frame with no gap required.
- Latency: 1 cycle. Pixel (row,col) is accepted at edge N. At edge N+1: window_out reflects it. ready=1 if and only if row >= 2R and col >= 2R. x_out = col-R and y_out = row-R (updated only when ready).
- Windows spanning a row wrap (col < 2R) or the first 2R rows of a frame (including stale previous-frame data) never assert ready.
- Ready windows per frame = (WIDTH-2R)*(HEIGHT-2R).
- frame_done=1 on the cycle after pixel (HEIGHT-1, WIDTH-1) is accepted, coincident with the final ready.
- Continuous write=1 is sustained at one pixel per cycle with no back-pressure. Downstream must sample window_out on every ready cycle.
- Widths: no arithmetic on pixel data; values pass through bit-exact.

Decomposition:
- Package window_buf_pkg: clog2 function, K and window-element-count localparam helpers, centre-index constant.
- Sub-module line_delay (DATA_W x WIDTH delay line, advance-on-enable, no reset on storage), instantiated 2*R_KERNEL times by generate.

Test Plan:
1. R=1, W=H=8, DATA_W=11; continuous write; pixel = row*8+col.
   -> First ready on the cycle after pixel (2,2); window = {0,1,2,8,9,10,16,17,18}; centre 9; x_out=1, y_out=1.
2. Same stream, full frame.
   -> Exactly 36 ready pulses and one frame_done. frame_done coincides with a window whose centre is 54 (x=6, y=6).
3. Same frame with write toggled every other cycle.
   -> Window/coordinate sequence identical to test 1; ready=0 on every cycle where write was 0 at the preceding edge.
4. Assert rst for 1 cycle after 20 pixels, then restream the frame.
   -> ready, frame_done and window_out are 0 the cycle after reset; results then match test 1 exactly.
5. R=2, W=H=9; pixel = row*9+col.
   -> First ready after pixel (4,4) with centre 20 (x=2, y=2); 25 ready pulses per frame.
6. Two back-to-back frames, R=1, W=H=8.
   -> No ready during rows 0-1 of frame 2; frame 2's first ready follows its pixel (2,2) with the same window as test 1.
